// File: rtl/rs_fifo_srl_ctrl_pkg.sv
// Shared helpers for the SRL FIFO controller: count width and parameter legality.
package rs_fifo_srl_ctrl_pkg;

  // Occupancy needs one more bit than the SRL address so it can reach DEPTH.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic bit params_legal(input int depth, input int addr_width, input int grace);
    return (depth >= 1) && (depth <= (1 << addr_width)) && (grace >= 0) && (grace < depth);
  endfunction

endpackage

// File: rtl/rs_fifo_srl_ctrl.sv
// Occupancy/address controller for an SRL shift-register FIFO: turns write/read
// handshakes into shift-enable and read-address, with registered empty/almost-full flags.
module rs_fifo_srl_ctrl
  import rs_fifo_srl_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int DEPTH        = 16,
  parameter int GRACE_PERIOD = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] srl_data,
  output logic                  srl_ce,
  output logic [ADDR_WIDTH-1:0] srl_a,
  input  logic [DATA_WIDTH-1:0] srl_q
);

  localparam int CW = cnt_width(ADDR_WIDTH);

  if (!params_legal(DEPTH, ADDR_WIDTH, GRACE_PERIOD)) begin : g_bad_params
    $error("rs_fifo_srl_ctrl: need 1 <= DEPTH <= 2**ADDR_WIDTH and 0 <= GRACE_PERIOD < DEPTH");
  end

  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]         CNT_TH   = CW'(DEPTH - GRACE_PERIOD);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic                  wr_req, pop, push;
  logic [CW-1:0]         next_count;
  logic [ADDR_WIDTH-1:0] ptr, next_ptr;

  assign wr_req = if_write & if_write_ce;
  assign pop    = if_read & if_read_ce & (count != '0);
  // A write at full is only accepted when the same-cycle pop frees the read slot.
  assign push   = wr_req & ((count < CNT_FULL) | pop);

  assign srl_ce   = push & reset_n;
  assign srl_data = if_din;
  assign srl_a    = ptr;
  assign if_dout  = srl_q;

  // ptr tracks the oldest word, which sits at count-1 in the shift chain.
  always_comb begin
    next_count = count;
    next_ptr   = ptr;
    if (push && !pop) begin
      next_count = count + CNT_ONE;
      if (count != '0) next_ptr = ptr + PTR_ONE;
    end else if (pop && !push) begin
      next_count = count - CNT_ONE;
      if (count != CNT_ONE) next_ptr = ptr - PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count      <= '0;
      ptr        <= '0;
      if_empty_n <= 1'b0;
      if_full_n  <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      count      <= next_count;
      ptr        <= next_ptr;
      if_empty_n <= (next_count != '0);
      if_full_n  <= (next_count < CNT_TH);
      if (wr_req && !push) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rs_fifo_srl_ctrl.sv
// Self-checking bench for rs_fifo_srl_ctrl against a queue-based FIFO reference model.
module tb_rs_fifo_srl_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int GRACE = 2;
  localparam int CW    = AW + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          if_write_ce = 1'b0, if_write = 1'b0;
  logic [DW-1:0] if_din = '0;
  logic          if_full_n;
  logic          if_read_ce = 1'b0, if_read = 1'b0;
  logic [DW-1:0] if_dout;
  logic          if_empty_n;
  logic [CW-1:0] count;
  logic          overflow;
  logic [DW-1:0] srl_data;
  logic          srl_ce;
  logic [AW-1:0] srl_a;
  logic [DW-1:0] srl_q;

  int n_tests = 0;
  int n_fail  = 0;

  rs_fifo_srl_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .GRACE_PERIOD(GRACE)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din), .if_full_n(if_full_n),
    .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout), .if_empty_n(if_empty_n),
    .count(count), .overflow(overflow),
    .srl_data(srl_data), .srl_ce(srl_ce), .srl_a(srl_a), .srl_q(srl_q)
  );

  always #5 clk = ~clk;

  // SRL storage primitive: shift on ce, combinational read at address a.
  logic [DW-1:0] srl_mem [DEPTH];
  always @(posedge clk) begin
    if (srl_ce) begin
      for (int i = DEPTH - 1; i > 0; i--) srl_mem[i] <= srl_mem[i-1];
      srl_mem[0] <= srl_data;
    end
  end
  assign srl_q = srl_mem[srl_a];

  // Reference model: FIFO contents as a queue plus the sticky overflow bit.
  logic [DW-1:0] m_q[$];
  bit            m_ovf = 1'b0;
  bit            exp_ce, obs_ce;
  logic [DW-1:0] obs_data;

  // One clock of stimulus; records srl_ce/srl_data mid-cycle and advances the model.
  task automatic step(input bit rn, input bit w, input bit wce, input bit r, input bit rce,
                      input logic [DW-1:0] d);
    bit mp, mw;
    reset_n = rn; if_write = w; if_write_ce = wce; if_read = r; if_read_ce = rce; if_din = d;
    #1;
    mp = r && rce && (m_q.size() != 0);
    mw = w && wce && ((m_q.size() < DEPTH) || mp);
    exp_ce   = mw && rn;
    obs_ce   = srl_ce;
    obs_data = srl_data;
    @(posedge clk); #1;
    if (!rn) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (mp) void'(m_q.pop_front());
      if (mw) m_q.push_back(d);
      if (w && wce && !mw) m_ovf = 1'b1;
    end
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, '0);
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 0, '0);
    step(0, 1, 1, 1, 1, 32'h55);
    n_tests++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_tests++; if (if_empty_n !== 1'b0) begin n_fail++; $display("FAIL reset_empty_n got %b exp 0", if_empty_n); end
    n_tests++; if (if_full_n !== 1'b1) begin n_fail++; $display("FAIL reset_full_n got %b exp 1", if_full_n); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    n_tests++; if (srl_a !== '0) begin n_fail++; $display("FAIL reset_srl_a got %0d exp 0", srl_a); end
    n_tests++; if (obs_ce !== 1'b0) begin n_fail++; $display("FAIL reset_srl_ce got %b exp 0", obs_ce); end
    step(1, 0, 0, 0, 0, '0);
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 14; i++) begin
      step(1, 1, 1, 0, 0, DW'(i));
      n_tests++; if (count !== CW'(i)) begin n_fail++; $display("FAIL fill_count got %0d exp %0d", count, i); end
      n_tests++; if (if_full_n !== (i < DEPTH - GRACE)) begin n_fail++; $display("FAIL fill_full_n[%0d] got %b exp %b", i, if_full_n, i < DEPTH - GRACE); end
      n_tests++; if (if_empty_n !== 1'b1) begin n_fail++; $display("FAIL fill_empty_n got %b exp 1", if_empty_n); end
      n_tests++; if (if_dout !== 32'h1) begin n_fail++; $display("FAIL fill_dout got %0h exp 1", if_dout); end
      n_tests++; if (srl_a !== AW'(i - 1)) begin n_fail++; $display("FAIL fill_srl_a got %0d exp %0d", srl_a, i - 1); end
    end
  endtask

  task automatic test_overflow();
    step(1, 1, 1, 0, 0, 32'hF);
    step(1, 1, 1, 0, 0, 32'h10);
    n_tests++; if (count !== CW'(16)) begin n_fail++; $display("FAIL ovf_count_full got %0d exp 16", count); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b exp 0", overflow); end
    step(1, 1, 1, 0, 0, 32'h99);
    n_tests++; if (obs_ce !== 1'b0) begin n_fail++; $display("FAIL ovf_srl_ce got %b exp 0", obs_ce); end
    n_tests++; if (count !== CW'(16)) begin n_fail++; $display("FAIL ovf_count got %0d exp 16", count); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    n_tests++; if (if_full_n !== 1'b0) begin n_fail++; $display("FAIL ovf_full_n got %b exp 0", if_full_n); end
    idle();
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
  endtask

  task automatic test_push_pop_full();
    step(1, 1, 1, 1, 1, 32'h11);
    n_tests++; if (obs_ce !== 1'b1) begin n_fail++; $display("FAIL pp_srl_ce got %b exp 1", obs_ce); end
    n_tests++; if (obs_data !== 32'h11) begin n_fail++; $display("FAIL pp_srl_data got %0h exp 11", obs_data); end
    n_tests++; if (count !== CW'(16)) begin n_fail++; $display("FAIL pp_count got %0d exp 16", count); end
    n_tests++; if (srl_a !== AW'(15)) begin n_fail++; $display("FAIL pp_srl_a got %0d exp 15", srl_a); end
    n_tests++; if (if_dout !== 32'h2) begin n_fail++; $display("FAIL pp_dout got %0h exp 2", if_dout); end
    for (int i = 0; i < 16; i++) begin
      n_tests++; if (if_dout !== DW'(i + 2)) begin n_fail++; $display("FAIL drain_dout[%0d] got %0h exp %0h", i, if_dout, i + 2); end
      step(1, 0, 0, 1, 1, '0);
    end
    n_tests++; if (count !== '0) begin n_fail++; $display("FAIL drain_count got %0d exp 0", count); end
    n_tests++; if (if_empty_n !== 1'b0) begin n_fail++; $display("FAIL drain_empty_n got %b exp 0", if_empty_n); end
    n_tests++; if (if_full_n !== 1'b1) begin n_fail++; $display("FAIL drain_full_n got %b exp 1", if_full_n); end
    step(1, 0, 0, 1, 1, '0);
    n_tests++; if (count !== '0 || srl_a !== '0) begin n_fail++; $display("FAIL empty_read count %0d srl_a %0d exp 0 0", count, srl_a); end
  endtask

  task automatic test_empty_rw();
    step(1, 1, 1, 1, 1, 32'hAA);
    n_tests++; if (obs_ce !== 1'b1) begin n_fail++; $display("FAIL erw_srl_ce got %b exp 1", obs_ce); end
    n_tests++; if (count !== CW'(1)) begin n_fail++; $display("FAIL erw_count got %0d exp 1", count); end
    n_tests++; if (if_dout !== 32'hAA) begin n_fail++; $display("FAIL erw_dout got %0h exp aa", if_dout); end
    n_tests++; if (if_empty_n !== 1'b1) begin n_fail++; $display("FAIL erw_empty_n got %b exp 1", if_empty_n); end
    n_tests++; if (srl_a !== '0) begin n_fail++; $display("FAIL erw_srl_a got %0d exp 0", srl_a); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0, DW'(32'hB0 + i));
    n_tests++; if (count !== CW'(5)) begin n_fail++; $display("FAIL rm_pre_count got %0d exp 5", count); end
    step(0, 1, 1, 0, 0, 32'hBF);
    n_tests++; if (obs_ce !== 1'b0) begin n_fail++; $display("FAIL rm_srl_ce got %b exp 0", obs_ce); end
    n_tests++; if (count !== '0) begin n_fail++; $display("FAIL rm_count got %0d exp 0", count); end
    n_tests++; if (if_empty_n !== 1'b0) begin n_fail++; $display("FAIL rm_empty_n got %b exp 0", if_empty_n); end
    n_tests++; if (if_full_n !== 1'b1) begin n_fail++; $display("FAIL rm_full_n got %b exp 1", if_full_n); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rm_overflow got %b exp 0", overflow); end
    n_tests++; if (srl_a !== '0) begin n_fail++; $display("FAIL rm_srl_a got %0d exp 0", srl_a); end
  endtask

  task automatic test_ce_low();
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, DW'(32'hC0 + i));
    step(1, 1, 0, 0, 0, 32'hDD);
    n_tests++; if (obs_ce !== 1'b0) begin n_fail++; $display("FAIL ce_w_srl_ce got %b exp 0", obs_ce); end
    step(1, 0, 0, 1, 0, '0);
    step(1, 1, 0, 1, 0, 32'hDE);
    n_tests++; if (count !== CW'(3)) begin n_fail++; $display("FAIL ce_count got %0d exp 3", count); end
    n_tests++; if (srl_a !== AW'(2)) begin n_fail++; $display("FAIL ce_srl_a got %0d exp 2", srl_a); end
    n_tests++; if (if_empty_n !== 1'b1 || if_full_n !== 1'b1) begin n_fail++; $display("FAIL ce_flags got %b%b exp 11", if_empty_n, if_full_n); end
    n_tests++; if (if_dout !== 32'hC0) begin n_fail++; $display("FAIL ce_dout got %0h exp c0", if_dout); end
    while (m_q.size() < DEPTH) step(1, 1, 1, 0, 0, DW'($urandom));
    step(1, 1, 0, 0, 0, 32'hEE);
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ce_no_overflow got %b exp 0", overflow); end
    n_tests++; if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL ce_full_count got %0d exp %0d", count, DEPTH); end
  endtask

  task automatic test_random();
    int wp, rp, sz;
    for (int c = 0; c < 3000; c++) begin
      wp = ((c / 250) % 2 == 0) ? 75 : 30;
      rp = 100 - wp;
      step($urandom_range(0, 199) != 0,
           $urandom_range(0, 99) < wp, $urandom_range(0, 9) != 0,
           $urandom_range(0, 99) < rp, $urandom_range(0, 9) != 0, DW'($urandom));
      sz = m_q.size();
      n_tests++; if (obs_ce !== exp_ce) begin n_fail++; $display("FAIL rnd_srl_ce[%0d] got %b exp %b", c, obs_ce, exp_ce); end
      n_tests++; if (count !== CW'(sz)) begin n_fail++; $display("FAIL rnd_count[%0d] got %0d exp %0d", c, count, sz); end
      n_tests++; if (if_empty_n !== (sz != 0)) begin n_fail++; $display("FAIL rnd_empty_n[%0d] got %b exp %b", c, if_empty_n, sz != 0); end
      n_tests++; if (if_full_n !== (sz < DEPTH - GRACE)) begin n_fail++; $display("FAIL rnd_full_n[%0d] got %b exp %b", c, if_full_n, sz < DEPTH - GRACE); end
      n_tests++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_overflow[%0d] got %b exp %b", c, overflow, m_ovf); end
      n_tests++; if (srl_a !== AW'((sz == 0) ? 0 : sz - 1)) begin n_fail++; $display("FAIL rnd_srl_a[%0d] got %0d exp %0d", c, srl_a, (sz == 0) ? 0 : sz - 1); end
      if (sz != 0) begin
        n_tests++; if (if_dout !== m_q[0]) begin n_fail++; $display("FAIL rnd_dout[%0d] got %0h exp %0h", c, if_dout, m_q[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_push_pop_full();
    test_empty_rw();
    test_reset_mid();
    test_ce_low();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_fifo_srl_ctrl.md
Name: rs_fifo_srl_ctrl

Overview:
Occupancy and address controller for the team's SRL shift-register FIFO storage primitive. That primitive has the interface data / ce / a / q: a synchronous shift on ce, with combinational read at address a.
- Converts write/read handshakes into SRL shift-enable and read-address control.
- Produces registered empty_n and almost-full (full_n) flags, an occupancy count and a sticky overflow flag.
- Sits between a producer and a consumer on every pipelined inter-module FIFO.

Parameters:
DATA_WIDTH, 32, width of each FIFO entry.
ADDR_WIDTH, 4, SRL address width; DEPTH <= 2**ADDR_WIDTH.
DEPTH, 16, number of SRL entries.
GRACE_PERIOD, 2, slots held in reserve after full_n deasserts; 0 <= GRACE_PERIOD < DEPTH.

Ports:
clk  input  1  clock, all state updates on the rising edge.
reset_n  input  1  synchronous, active-low reset.
if_write_ce  input  1  write-side enable.
if_write  input  1  write request.
if_din  input  DATA_WIDTH  write data.
if_full_n  output  1  registered; 1 = occupancy below DEPTH-GRACE_PERIOD.
if_read_ce  input  1  read-side enable.
if_read  input  1  read request (pop).
if_dout  output  DATA_WIDTH  head-of-FIFO data, first-word fall-through.
if_empty_n  output  1  registered; 1 = at least one entry present.
count  output  ADDR_WIDTH+1  registered occupancy, 0..DEPTH.
overflow  output  1  sticky; set when a write is dropped.
srl_data  output  DATA_WIDTH  data to SRL, equal to if_din.
srl_ce  output  1  SRL shift enable.
srl_a  output  ADDR_WIDTH  SRL read address, registered pointer.
srl_q  input  DATA_WIDTH  SRL read data.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-low (reset_n). It is sampled only at a clk edge and has priority over all other updates.
- Reset values:
  - count=0, ptr(srl_a)=0, if_empty_n=0.
  - if_full_n=1 (if GRACE_PERIOD<DEPTH).
  - overflow=0.
  - Pending SRL contents are abandoned; srl_ce is forced to 0 during reset.
- Acceptance (combinational):
  - pop = if_read & if_read_ce & (count!=0).
  - push = if_write & if_write_ce & ((count<DEPTH) | pop).
  - A push while full is legal only together with a pop. The shift discards the slot being read this cycle.
- srl_ce = push & reset_n. srl_data = if_din. if_dout = srl_q (valid only while if_empty_n=1).
- Latency: a written word is visible on if_dout the cycle after its push edge (if_empty_n rises the same edge).
- Pointer/count update by case:
  - push & !pop: count+1. ptr holds if count==0, else ptr+1.
  - pop & !push: count-1. ptr holds if count==1, else ptr-1.
  - push & pop: count and ptr unchanged. The shift moves the next-oldest word into the ptr slot.
  - Neither: hold.
- Invariant: count>0 implies ptr==count-1; count==0 implies ptr==0.
- Flags are computed from next-count and registered:
  - if_empty_n = (next_count!=0).
  - if_full_n = (next_count < DEPTH-GRACE_PERIOD).
- Writes are still accepted while if_full_n=0, up to DEPTH. This absorbs producer pipeline latency.
- overflow is set when if_write & if_write_ce & !push. It clears only on reset.
- Read on empty: ignored, no state change, if_dout undefined.
- Enables low: a request with its ce=0 is not a handshake and has no effect, including on overflow.
- Reset mid-operation: all data discarded, flags return to reset values next cycle regardless of a concurrent push/pop.
- No state machine beyond the count/ptr registers; the whole block is a single always block plus combinational accept logic.

Decomposition:
- Shared package: count width (ADDR_WIDTH+1) helper and the parameter legality checks (DEPTH <= 2**ADDR_WIDTH, GRACE_PERIOD < DEPTH), both as elaboration-time assertions.
- No sub-module inside the controller.
- A thin top wrapper instantiates rs_fifo_srl_ctrl plus the existing SRL storage primitive, connecting srl_* one-to-one.

Test Plan:
1. Reset with DEPTH=16, GRACE=2, then write 0x1..0xE on consecutive cycles -> count reaches 14. if_full_n falls on the edge where count becomes 14. if_empty_n=1 from the first edge. if_dout=0x1 throughout.
2. Continue writing 0xF, 0x10, then one more write with no read -> 0xF and 0x10 are accepted (count=16). The third write is dropped: overflow=1 sticky, count stays 16, srl_ce=0.
3. From full, assert read and write simultaneously with din=0x11 -> both accepted, count=16, srl_a=15, if_dout advances to 0x2. After draining 16 reads, the output sequence is 0x2..0x11.
4. From empty, assert simultaneous read and write of 0xAA -> pop rejected, push accepted. count=1, if_dout=0xAA next cycle, if_empty_n=1.
5. Fill to 5 entries, assert reset_n=0 for one cycle concurrent with a push -> next cycle count=0, if_empty_n=0, if_full_n=1, overflow=0, srl_a=0.
6. Requests with if_write_ce=0 / if_read_ce=0 at count=3 -> count, srl_a=2 and flags unchanged, srl_ce=0.
